score_tracker: RTL and testbench
================================

SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players (2..7).
REQ-002 Parameter SCORE_W, default 5, per-player score width.
REQ-003 Parameter MATCH_POINTS, default 3, wins needed to take a match; 0 disables match ending; must be <= 2^SCORE_W-1.
REQ-004 Parameter CODE_W, default 2, win_code width; must satisfy 2^CODE_W >= NUM_PLAYERS+2.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 globalReset_n  input  1  reset, asynchronous, active-low.
REQ-007 win_code  input  CODE_W  round result, synchronous to clk: 0 none, p+1 player p wins, NUM_PLAYERS+1 draw, larger values illegal.
REQ-008 new_match  input  1  synchronous single-cycle request to clear scores and start a match.
REQ-009 score  output  NUM_PLAYERS*SCORE_W  packed scores, player p at bits [p*SCORE_W +: SCORE_W].
REQ-010 draw_count  output  SCORE_W  number of drawn rounds this match.
REQ-011 round_done  output  1  one-cycle pulse, a round result was accepted.
REQ-012 match_over  output  1  level, high while a match winner is held.
REQ-013 match_winner  output  CODE_W  winning player index, valid while match_over is high, else 0.
REQ-014 illegal_code  output  1  one-cycle pulse, illegal win_code sampled in PLAY.

Function
REQ-015 FSM states: PLAY (accept a result), HOLD (wait for win_code to return to 0), OVER (match finished, results ignored).
REQ-016 PLAY, legal nonzero win_code at an edge: counter updated at that edge, round_done high the following cycle, next state HOLD.
REQ-017 Player win: score[p] incremented by 1, saturating at 2^SCORE_W-1.
REQ-018 Draw: draw_count incremented by 1, saturating; scores unchanged.
REQ-019 Player win bringing score[p] to MATCH_POINTS (MATCH_POINTS != 0): next state OVER, match_over high and match_winner = p from the following cycle.
REQ-020 HOLD: win_code ignored until sampled 0; win_code 0 gives PLAY next cycle; a direct change between nonzero codes gives no count.
REQ-021 PLAY, illegal win_code: no counter change, illegal_code pulses the following cycle, next state HOLD.
REQ-022 OVER: win_code ignored, scores and match_winner frozen until new_match.
REQ-023 new_match in any state: all scores and draw_count cleared to 0, match_over low, match_winner 0, next state HOLD.
REQ-024 new_match together with a result at the same edge: new_match wins and the result is discarded (no round_done).
REQ-025 Each accepted result produces exactly one round_done pulse; no combinational path from inputs to outputs.

Reset
REQ-026 globalReset_n low asynchronously forces state HOLD, all scores 0, draw_count 0, round_done 0, match_over 0, match_winner 0, illegal_code 0.
REQ-027 Reset asserted mid-round aborts the round with no count; after release the FSM requires win_code = 0 before counting.

Structure
REQ-028 Shared package score_pkg holds the FSM state enum and helper constants (CODE_NONE, draw-code function of NUM_PLAYERS).
REQ-029 One sub-module score_counter (SCORE_W-bit saturating counter with inc and clear) is instantiated NUM_PLAYERS+1 times, once per player plus once for draws.

Verification
REQ-030 Reset, then win_code 1 for 3 cycles, then 0 -> score[0]=1, one round_done pulse, state HOLD then PLAY.
REQ-031 Defaults: rounds 1,2,3,1,1 each separated by 0 -> after round 5 score = {1,3}, draw_count=1, match_over=1, match_winner=0; further code 2 ignored.
REQ-032 win_code 1 held, switched directly to 2, then 0 -> only score[0]=1 counted.
REQ-033 SCORE_W=2, MATCH_POINTS=0: five code-2 rounds -> score[1] saturates at 3, no match_over.
REQ-034 NUM_PLAYERS=2, CODE_W=3: win_code 5 in PLAY -> illegal_code pulse, no count; new_match with win_code 1 at the same edge -> all scores 0, no round_done.
REQ-035 globalReset_n dropped asynchronously during HOLD with score[0]=2 -> all outputs 0 immediately; after release, win_code held at 1 is not counted until it returns to 0.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared FSM state type and win_code helpers for score_tracker.
package score_pkg;
  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;
  localparam int CODE_NONE = 0;
  function automatic int draw_code(input int num_players);
    return num_players + 1;
  endfunction
endpackage

// File: rtl/score_counter.sv
// score_counter: W-bit saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one (holds at all-ones)
//   clear      : synchronous clear, has priority over inc
//   count      : current value
module score_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/score_tracker.sv
// score_tracker: per-player score keeper with draw counting and match end.
//   clk, globalReset_n : clock, asynchronous active-low reset
//   win_code           : 0 none, p+1 player p wins, NUM_PLAYERS+1 draw, above illegal
//   new_match          : clear all counters and wait for win_code to return to 0
//   score              : packed scores, player p at [p*SCORE_W +: SCORE_W]
//   draw_count         : drawn rounds this match
//   round_done         : pulse, a result was accepted on the previous edge
//   match_over         : level, a match winner is held
//   match_winner       : winning player index while match_over, else 0
//   illegal_code       : pulse, an illegal code was sampled while accepting results
module score_tracker
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 5,
  parameter int MATCH_POINTS = 3,
  parameter int CODE_W       = 2
) (
  input  logic                           clk,
  input  logic                           globalReset_n,
  input  logic [CODE_W-1:0]              win_code,
  input  logic                           new_match,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [SCORE_W-1:0]             draw_count,
  output logic                           round_done,
  output logic                           match_over,
  output logic [CODE_W-1:0]              match_winner,
  output logic                           illegal_code
);
  localparam logic [CODE_W-1:0] NONE = CODE_W'(CODE_NONE);
  localparam logic [CODE_W-1:0] DRAW = CODE_W'(draw_code(NUM_PLAYERS));
  state_t state, state_nx;
  logic [NUM_PLAYERS-1:0] inc, win;
  logic play, accept, any_win;
  logic [CODE_W-1:0] win_idx;
  // new_match overrides any result sampled at the same edge
  assign play    = state == PLAY && !new_match;
  assign accept  = play && win_code != NONE && win_code <= DRAW;
  assign any_win = |win;
  genvar p;
  for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign inc[p] = accept && win_code == CODE_W'(p + 1);
    // the win that lands this edge brings the score to MATCH_POINTS
    assign win[p] = inc[p] && MATCH_POINTS != 0 &&
                    score[p*SCORE_W +: SCORE_W] == SCORE_W'(MATCH_POINTS - 1);
    score_counter #(.W(SCORE_W)) u_player (
      .clk(clk), .rst_n(globalReset_n), .inc(inc[p]), .clear(new_match),
      .count(score[p*SCORE_W +: SCORE_W])
    );
  end
  score_counter #(.W(SCORE_W)) u_draw (
    .clk(clk), .rst_n(globalReset_n), .inc(accept && win_code == DRAW), .clear(new_match),
    .count(draw_count)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (win[i]) win_idx = CODE_W'(i);
  end
  always_comb
    state_nx = new_match      ? HOLD :
               state == PLAY  ? (win_code == NONE ? PLAY : any_win ? OVER : HOLD) :
               state == HOLD  ? (win_code == NONE ? PLAY : HOLD) : state;
  always_ff @(posedge clk or negedge globalReset_n)
    if (!globalReset_n) begin
      state        <= HOLD;
      round_done   <= 1'b0;
      illegal_code <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= '0;
    end else begin
      state        <= state_nx;
      round_done   <= accept;
      illegal_code <= play && win_code > DRAW;
      match_over   <= new_match ? 1'b0 : any_win ? 1'b1 : match_over;
      match_winner <= new_match ? '0 : any_win ? win_idx : match_winner;
    end
endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed and random checks of two score_tracker configurations.
module tb_score_tracker;
  logic clk = 1'b0;
  logic rst_n, nm;
  logic [2:0] wc;
  logic [9:0] score_a;
  logic [4:0] draw_a;
  logic [1:0] mw_a;
  logic rd_a, mo_a, il_a;
  logic [3:0] score_b;
  logic [1:0] draw_b;
  logic [2:0] mw_b;
  logic rd_b, mo_b, il_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  score_tracker u_a (
    .clk(clk), .globalReset_n(rst_n), .win_code(wc[1:0]), .new_match(nm),
    .score(score_a), .draw_count(draw_a), .round_done(rd_a), .match_over(mo_a),
    .match_winner(mw_a), .illegal_code(il_a)
  );
  score_tracker #(.NUM_PLAYERS(2), .SCORE_W(2), .MATCH_POINTS(0), .CODE_W(3)) u_b (
    .clk(clk), .globalReset_n(rst_n), .win_code(wc), .new_match(nm),
    .score(score_b), .draw_count(draw_b), .round_done(rd_b), .match_over(mo_b),
    .match_winner(mw_b), .illegal_code(il_b)
  );
  // behavioural model, index 0 = u_a, 1 = u_b
  int  sw[2] = '{5, 2};
  int  mp[2] = '{3, 0};
  int  m_sc[2][2] = '{'{0, 0}, '{0, 0}};
  int  m_dr[2] = '{0, 0};
  int  m_wn[2] = '{0, 0};
  bit  m_ov[2] = '{0, 0};
  bit  m_wt[2] = '{1, 1};
  bit  m_rd[2] = '{0, 0};
  bit  m_il[2] = '{0, 0};
  function automatic void m_clear(input int d);
    m_sc[d][0] = 0; m_sc[d][1] = 0; m_dr[d] = 0;
    m_ov[d] = 0; m_wn[d] = 0; m_wt[d] = 1;
    m_rd[d] = 0; m_il[d] = 0;
  endfunction
  function automatic void m_step(input int d, input int c, input bit n);
    int mx = (1 << sw[d]) - 1;
    m_rd[d] = 0;
    m_il[d] = 0;
    if (n) m_clear(d);
    else if (m_ov[d]) ;
    else if (m_wt[d]) m_wt[d] = (c != 0);
    else if (c != 0) begin
      m_wt[d] = 1;
      if (c <= 2) begin
        if (m_sc[d][c-1] < mx) m_sc[d][c-1]++;
        m_rd[d] = 1;
        if (mp[d] != 0 && m_sc[d][c-1] == mp[d]) begin
          m_ov[d] = 1;
          m_wn[d] = c - 1;
        end
      end else if (c == 3) begin
        if (m_dr[d] < mx) m_dr[d]++;
        m_rd[d] = 1;
      end else m_il[d] = 1;
    end
  endfunction
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (!rst_n) m_clear(d);
      else m_step(d, d == 0 ? int'(wc[1:0]) : int'(wc), nm);
  always @(negedge rst_n)
    for (int d = 0; d < 2; d++) m_clear(d);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("score_a", 32'(score_a), 32'((m_sc[0][1] << 5) | m_sc[0][0]));
    chk("draw_a", 32'(draw_a), 32'(m_dr[0]));
    chk("round_done_a", 32'(rd_a), 32'(m_rd[0]));
    chk("match_over_a", 32'(mo_a), 32'(m_ov[0]));
    chk("winner_a", 32'(mw_a), 32'(m_wn[0]));
    chk("illegal_a", 32'(il_a), 32'(m_il[0]));
    chk("score_b", 32'(score_b), 32'((m_sc[1][1] << 2) | m_sc[1][0]));
    chk("draw_b", 32'(draw_b), 32'(m_dr[1]));
    chk("round_done_b", 32'(rd_b), 32'(m_rd[1]));
    chk("match_over_b", 32'(mo_b), 32'(m_ov[1]));
    chk("winner_b", 32'(mw_b), 32'(m_wn[1]));
    chk("illegal_b", 32'(il_b), 32'(m_il[1]));
  end
  task automatic cyc(input int c, input bit n);
    wc = 3'(c);
    nm = n;
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; nm = 1'b0; wc = '0;
    cyc(0, 0); cyc(0, 0);
    rst_n = 1'b1;
    chk("lit_reset_score", 32'(score_a), 0);
    chk("lit_reset_over", 32'(mo_a), 0);
    cyc(0, 0);
    cyc(1, 0);
    chk("lit_first_round_done", 32'(rd_a), 1);
    chk("lit_first_score", 32'(score_a), 1);
    cyc(1, 0);
    chk("lit_held_no_pulse", 32'(rd_a), 0);
    cyc(1, 0); cyc(0, 0);
    chk("lit_held_score", 32'(score_a), 1);
    cyc(0, 1); cyc(0, 0);
    foreach (m_dr[k]) ;
    for (int i = 0; i < 5; i++) begin
      cyc(i == 1 ? 2 : i == 2 ? 3 : 1, 0);
      cyc(0, 0);
    end
    chk("lit_match_over", 32'(mo_a), 1);
    chk("lit_match_score", 32'(score_a), 35);
    chk("lit_match_draw", 32'(draw_a), 1);
    chk("lit_match_winner", 32'(mw_a), 0);
    chk("lit_b_score", 32'(score_b), 7);
    cyc(2, 0); cyc(0, 0);
    chk("lit_over_frozen", 32'(score_a), 35);
    cyc(0, 1); cyc(0, 0);
    cyc(1, 0); cyc(1, 0); cyc(2, 0); cyc(2, 0); cyc(0, 0);
    chk("lit_direct_change", 32'(score_a), 1);
    cyc(0, 1); cyc(0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(2, 0);
      cyc(0, 0);
    end
    chk("lit_b_saturate", 32'(score_b), 12);
    chk("lit_b_no_over", 32'(mo_b), 0);
    chk("lit_a_winner1", 32'(mw_a), 1);
    cyc(0, 1); cyc(0, 0);
    cyc(5, 0);
    chk("lit_b_illegal", 32'(il_b), 1);
    chk("lit_b_illegal_nocount", 32'(score_b), 0);
    cyc(0, 0);
    cyc(1, 1);
    chk("lit_nm_clear", 32'(score_a), 0);
    chk("lit_nm_no_done", 32'(rd_a), 0);
    cyc(0, 0);
    cyc(1, 0); cyc(0, 0); cyc(1, 0);
    chk("lit_pre_reset", 32'(score_a), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_score", 32'(score_a), 0);
    chk("lit_async_done", 32'(rd_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    chk("lit_post_reset_held", 32'(score_a), 0);
    cyc(0, 0); cyc(1, 0);
    chk("lit_post_reset_count", 32'(score_a), 1);
    for (int i = 0; i < 3000; i++) begin
      int c;
      c = $urandom_range(0, 1) ? 0 : $urandom_range(1, 7);
      if ($urandom_range(0, 199) == 0) begin
        wc = 3'(c);
        nm = 1'b0;
        @(posedge clk);
        #($urandom_range(1, 4)) rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else cyc(c, $urandom_range(0, 31) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
